// File: rtl/e203_exu_csrctrl_mc_pkg.sv
// Shared definitions for the multi-channel CSR control stage: decode-info field
// positions, external-sequencer state encoding and default channel base index.
`ifndef E203_DECINFO_CSR_WIDTH
`define E203_DECINFO_CSR_CSRRW   0
`define E203_DECINFO_CSR_CSRRS   1
`define E203_DECINFO_CSR_CSRRC   2
`define E203_DECINFO_CSR_RS1IMM  3
`define E203_DECINFO_CSR_ZIMMM   8:4
`define E203_DECINFO_CSR_RS1IS0  9
`define E203_DECINFO_CSR_CSRIDX  21:10
`define E203_DECINFO_CSR_WIDTH   22
`endif

package e203_exu_csrctrl_mc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4,
        ST_DONE    = 3'd5
    } csr_state_e;

    localparam logic [3:0] EXT_IDX_BASE_DEF = 4'hE;

    function automatic logic is_wait(input csr_state_e st);
        return (st == ST_RD_WAIT) || (st == ST_WR_WAIT);
    endfunction

endpackage

// File: rtl/e203_exu_csrctrl_alu.sv
// CSRRW/CSRRS/CSRRC new-value computation, shared by the core and external paths.
module e203_exu_csrctrl_alu #(
    parameter int XLEN = 32
) (
    input  logic            is_rw,
    input  logic            is_rs,
    input  logic            is_rc,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] old_val,
    output logic [XLEN-1:0] new_val
);

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        new_val = '0;
        if (is_rw)      new_val = op1;
        else if (is_rs) new_val = op1 | old_val;
        else if (is_rc) new_val = ~op1 & old_val;
    end

endmodule

// File: rtl/e203_exu_csrctrl_mc.sv
// CSR control stage: zero-latency core CSR path plus a sequenced read-modify-write
// engine for external coprocessor CSR channels. Optional: E203_CSRCTRL_TIMEOUT_EN.
module e203_exu_csrctrl_mc
    import e203_exu_csrctrl_mc_pkg::*;
#(
    parameter int         XLEN         = 32,
    parameter int         NUM_EXT      = 2,
    parameter logic [3:0] EXT_IDX_BASE = EXT_IDX_BASE_DEF,
    parameter int         TIMEOUT_CYC  = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              csr_i_valid,
    output logic                              csr_i_ready,
    input  logic [XLEN-1:0]                   csr_i_rs1,
    input  logic [`E203_DECINFO_CSR_WIDTH-1:0] csr_i_info,
    input  logic                              csr_i_rdwen,
    output logic                              csr_ena,
    output logic                              csr_wr_en,
    output logic                              csr_rd_en,
    output logic [11:0]                       csr_idx,
    input  logic                              csr_access_ilgl,
    input  logic [XLEN-1:0]                   read_csr_dat,
    output logic [XLEN-1:0]                   wbck_csr_dat,
    input  logic [NUM_EXT-1:0]                ext_xs_off,
    output logic [NUM_EXT-1:0]                ext_req_valid,
    input  logic [NUM_EXT-1:0]                ext_req_ready,
    output logic                              ext_req_wr,
    output logic [11:0]                       ext_req_addr,
    output logic [XLEN-1:0]                   ext_req_wdata,
    input  logic [NUM_EXT-1:0]                ext_rsp_valid,
    input  logic [NUM_EXT*XLEN-1:0]           ext_rsp_rdata,
    input  logic [NUM_EXT-1:0]                ext_rsp_err,
    output logic                              csr_o_valid,
    input  logic                              csr_o_ready,
    output logic [XLEN-1:0]                   csr_o_wbck_wdat,
    output logic                              csr_o_wbck_err
);

    logic            is_rw, is_rs, is_rc, rs1imm, rs1is0;
    logic [4:0]      zimm;
    logic [XLEN-1:0] op1, alu_old, alu_new;

    assign is_rw   = csr_i_info[`E203_DECINFO_CSR_CSRRW];
    assign is_rs   = csr_i_info[`E203_DECINFO_CSR_CSRRS];
    assign is_rc   = csr_i_info[`E203_DECINFO_CSR_CSRRC];
    assign rs1imm  = csr_i_info[`E203_DECINFO_CSR_RS1IMM];
    assign rs1is0  = csr_i_info[`E203_DECINFO_CSR_RS1IS0];
    assign zimm    = csr_i_info[`E203_DECINFO_CSR_ZIMMM];
    assign csr_idx = csr_i_info[`E203_DECINFO_CSR_CSRIDX];
    assign op1     = rs1imm ? XLEN'(zimm) : csr_i_rs1;

    csr_state_e state_q, state_d;
    logic [XLEN-1:0] old_q;
    logic            err_q;

    // Decode into a one-hot channel mask; inputs are held stable for the whole operation.
    logic [4:0]         ch_off;
    logic               in_range, sel_ext;
    logic [NUM_EXT-1:0] ch_oh;
    logic               req_rdy, rsp_vld, rsp_err;
    logic [XLEN-1:0]    rsp_rdata;

    assign ch_off   = {1'b0, csr_idx[11:8]} - {1'b0, EXT_IDX_BASE};
    assign in_range = ch_off < 5'(NUM_EXT);
    assign ch_oh    = in_range ? (NUM_EXT'(1) << ch_off) : '0;
    assign sel_ext  = |(ch_oh & ~ext_xs_off);
    assign req_rdy  = |(ch_oh & ext_req_ready);
    assign rsp_vld  = |(ch_oh & ext_rsp_valid);
    assign rsp_err  = |(ch_oh & ext_rsp_err);

    always_comb begin
        rsp_rdata = '0;
        for (int k = 0; k < NUM_EXT; k++)
            if (ch_oh[k]) rsp_rdata = rsp_rdata | ext_rsp_rdata[k*XLEN +: XLEN];
    end

    assign alu_old = (state_q == ST_IDLE) ? read_csr_dat : old_q;

    e203_exu_csrctrl_alu #(.XLEN(XLEN)) u_alu (
        .is_rw   (is_rw),
        .is_rs   (is_rs),
        .is_rc   (is_rc),
        .op1     (op1),
        .old_val (alu_old),
        .new_val (alu_new)
    );

    assign wbck_csr_dat  = alu_new;
    assign ext_req_wdata = alu_new;
    assign ext_req_addr  = csr_idx;

    logic timeout;
`ifdef E203_CSRCTRL_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    logic [TMR_W-1:0] timer_q;
    assign timeout = (timer_q == TMR_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    logic req_phase, start_op, cap_old, set_err, skip_wr;
    assign skip_wr = ~is_rw & rs1is0;

    always_comb begin
        state_d         = state_q;
        csr_i_ready     = 1'b0;
        csr_o_valid     = 1'b0;
        csr_o_wbck_wdat = old_q;
        csr_o_wbck_err  = err_q;
        csr_ena         = 1'b0;
        csr_rd_en       = 1'b0;
        csr_wr_en       = 1'b0;
        req_phase       = 1'b0;
        ext_req_wr      = 1'b0;
        start_op        = 1'b0;
        cap_old         = 1'b0;
        set_err         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (sel_ext) begin
                    if (csr_i_valid) begin
                        start_op = 1'b1;
                        state_d  = (is_rw & ~csr_i_rdwen) ? ST_WR_REQ : ST_RD_REQ;
                    end
                end else begin
                    csr_o_valid     = csr_i_valid;
                    csr_i_ready     = csr_o_ready;
                    csr_rd_en       = csr_i_valid & (is_rw ? csr_i_rdwen : 1'b1);
                    csr_wr_en       = csr_i_valid & (is_rw | ~rs1is0);
                    csr_ena         = csr_i_valid & csr_o_ready;
                    csr_o_wbck_wdat = read_csr_dat;
                    csr_o_wbck_err  = csr_access_ilgl;
                end
            end
            ST_RD_REQ: begin
                req_phase = 1'b1;
                if (req_rdy) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (rsp_vld) begin
                    cap_old = 1'b1;
                    set_err = rsp_err;
                    state_d = (rsp_err | skip_wr) ? ST_DONE : ST_WR_REQ;
                end else if (timeout) begin
                    set_err = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_WR_REQ: begin
                req_phase  = 1'b1;
                ext_req_wr = 1'b1;
                if (req_rdy) state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                ext_req_wr = 1'b1;
                if (rsp_vld) begin
                    set_err = rsp_err;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    set_err = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                csr_o_valid = 1'b1;
                csr_i_ready = csr_o_ready;
                if (csr_o_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ext_req_valid = ch_oh & {NUM_EXT{req_phase}};

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            old_q   <= '0;
            err_q   <= 1'b0;
`ifdef E203_CSRCTRL_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (start_op) begin
                old_q <= '0;
                err_q <= 1'b0;
            end else begin
                if (cap_old) old_q <= rsp_rdata;
                if (set_err) err_q <= 1'b1;
            end
`ifdef E203_CSRCTRL_TIMEOUT_EN
            timer_q <= (is_wait(state_q) && state_d == state_q) ? timer_q + 1'b1 : '0;
`endif
        end
    end

endmodule

// File: tb/tb_e203_exu_csrctrl_mc.sv
// Self-checking bench for e203_exu_csrctrl_mc: directed cases plus randomized
// core/external CSR operations against a behavioural model.
module tb_e203_exu_csrctrl_mc;

    localparam int XLEN = 32;
    localparam int NEXT = 2;
    localparam int OP_RW = 0, OP_RS = 1, OP_RC = 2;

    logic                              clk = 1'b0;
    logic                              rst_n;
    logic                              csr_i_valid, csr_i_ready;
    logic [XLEN-1:0]                   csr_i_rs1;
    logic [`E203_DECINFO_CSR_WIDTH-1:0] csr_i_info;
    logic                              csr_i_rdwen;
    logic                              csr_ena, csr_wr_en, csr_rd_en;
    logic [11:0]                       csr_idx;
    logic                              csr_access_ilgl;
    logic [XLEN-1:0]                   read_csr_dat, wbck_csr_dat;
    logic [NEXT-1:0]                   ext_xs_off, ext_req_valid, ext_req_ready;
    logic                              ext_req_wr;
    logic [11:0]                       ext_req_addr;
    logic [XLEN-1:0]                   ext_req_wdata;
    logic [NEXT-1:0]                   ext_rsp_valid, ext_rsp_err;
    logic [NEXT*XLEN-1:0]              ext_rsp_rdata;
    logic                              csr_o_valid, csr_o_ready;
    logic [XLEN-1:0]                   csr_o_wbck_wdat;
    logic                              csr_o_wbck_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    e203_exu_csrctrl_mc #(
        .XLEN(XLEN), .NUM_EXT(NEXT), .EXT_IDX_BASE(4'hE), .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_i_valid(csr_i_valid), .csr_i_ready(csr_i_ready),
        .csr_i_rs1(csr_i_rs1), .csr_i_info(csr_i_info), .csr_i_rdwen(csr_i_rdwen),
        .csr_ena(csr_ena), .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en),
        .csr_idx(csr_idx), .csr_access_ilgl(csr_access_ilgl),
        .read_csr_dat(read_csr_dat), .wbck_csr_dat(wbck_csr_dat),
        .ext_xs_off(ext_xs_off), .ext_req_valid(ext_req_valid), .ext_req_ready(ext_req_ready),
        .ext_req_wr(ext_req_wr), .ext_req_addr(ext_req_addr), .ext_req_wdata(ext_req_wdata),
        .ext_rsp_valid(ext_rsp_valid), .ext_rsp_rdata(ext_rsp_rdata), .ext_rsp_err(ext_rsp_err),
        .csr_o_valid(csr_o_valid), .csr_o_ready(csr_o_ready),
        .csr_o_wbck_wdat(csr_o_wbck_wdat), .csr_o_wbck_err(csr_o_wbck_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] model_new(input int op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] old);
        case (op)
            OP_RW:   return a;
            OP_RS:   return a | old;
            default: return ~a & old;
        endcase
    endfunction

    function automatic logic [`E203_DECINFO_CSR_WIDTH-1:0] mk_info(input int op, input bit imm,
            input logic [4:0] zimm, input bit rs1is0, input logic [11:0] idx);
        logic [`E203_DECINFO_CSR_WIDTH-1:0] v;
        v = '0;
        v[`E203_DECINFO_CSR_CSRRW]  = (op == OP_RW);
        v[`E203_DECINFO_CSR_CSRRS]  = (op == OP_RS);
        v[`E203_DECINFO_CSR_CSRRC]  = (op == OP_RC);
        v[`E203_DECINFO_CSR_RS1IMM] = imm;
        v[`E203_DECINFO_CSR_ZIMMM]  = zimm;
        v[`E203_DECINFO_CSR_RS1IS0] = rs1is0;
        v[`E203_DECINFO_CSR_CSRIDX] = idx;
        return v;
    endfunction

    task automatic clear_rsp();
        ext_req_ready = '0;
        ext_rsp_valid = '0;
        ext_rsp_err   = '0;
        ext_rsp_rdata = '0;
    endtask

    // Arrive and leave 2 time units after a rising edge; the DUT sits in the request state.
    task automatic do_phase(input int ch, input bit wr, input logic [11:0] idx,
                            input logic [XLEN-1:0] exp_wdata, input logic [XLEN-1:0] rdata,
                            input bit err, input int rdy_dly, input int rsp_dly);
        logic [NEXT-1:0] oh;
        oh = NEXT'(1) << ch;
        for (int k = 0; k <= rdy_dly; k++) begin
            check(wr ? "wr_req_valid" : "rd_req_valid", ext_req_valid, oh);
            check("req_wr", ext_req_wr, wr);
            check("req_addr", ext_req_addr, idx);
            if (wr) check("req_wdata", ext_req_wdata, exp_wdata);
            check("core_quiet", {csr_ena, csr_rd_en, csr_wr_en, csr_o_valid}, 4'b0);
            if (k == rdy_dly) begin
                ext_req_ready[ch] = 1'b1;
                ext_rsp_valid[ch] = 1'b1;
                ext_rsp_err[ch]   = 1'b1;
                ext_rsp_rdata[ch*XLEN +: XLEN] = ~rdata;
            end
            @(posedge clk); #1; clear_rsp(); #1;
        end
        for (int k = 0; k <= rsp_dly; k++) begin
            check("wait_no_req", ext_req_valid, '0);
            check("wait_no_ovalid", csr_o_valid, 1'b0);
            if (k == rsp_dly) begin
                ext_rsp_valid[ch] = 1'b1;
                ext_rsp_err[ch]   = err;
                ext_rsp_rdata[ch*XLEN +: XLEN] = rdata;
            end else begin
                ext_rsp_valid[ch^1] = 1'b1;
                ext_rsp_err[ch^1]   = 1'b1;
                ext_rsp_rdata[(ch^1)*XLEN +: XLEN] = $urandom;
            end
            @(posedge clk); #1; clear_rsp(); #1;
        end
    endtask

    task automatic ext_op(input logic [11:0] idx, input int op, input bit imm,
                          input logic [XLEN-1:0] rs1v, input logic [4:0] zimm, input bit rs1is0,
                          input bit rdwen, input logic [XLEN-1:0] old, input bit err_rd,
                          input bit err_wr, input bit rnd);
        int ch, start, exp_lat, d0, d1, d2, d3, hold;
        bit do_rd, do_wr, exp_err;
        logic [XLEN-1:0] op1, exp_wdata, exp_wbck;
        ch        = int'(idx[11:8]) - 14;
        op1       = imm ? XLEN'(zimm) : rs1v;
        do_rd     = !(op == OP_RW && !rdwen);
        do_wr     = !(op != OP_RW && rs1is0) && !(do_rd && err_rd);
        exp_wbck  = do_rd ? old : '0;
        exp_wdata = model_new(op, op1, exp_wbck);
        exp_err   = (do_rd && err_rd) || (do_wr && err_wr);
        d0 = rnd ? $urandom_range(2) : 0; d1 = rnd ? $urandom_range(2) : 0;
        d2 = rnd ? $urandom_range(2) : 0; d3 = rnd ? $urandom_range(2) : 0;
        exp_lat = 1 + (do_rd ? 2 + d0 + d1 : 0) + (do_wr ? 2 + d2 + d3 : 0);

        @(posedge clk); #1;
        csr_i_valid = 1'b1; csr_i_rs1 = rs1v; csr_i_rdwen = rdwen;
        csr_i_info  = mk_info(op, imm, zimm, rs1is0, idx);
        read_csr_dat = $urandom; csr_access_ilgl = 1'b0; csr_o_ready = 1'b0;
        #1;
        start = cyc;
        check("ext_idle_quiet", {csr_o_valid, csr_i_ready, csr_ena, csr_rd_en, csr_wr_en}, 5'b0);
        check("ext_idle_noreq", ext_req_valid, '0);
        @(posedge clk); #2;
        if (do_rd) do_phase(ch, 1'b0, idx, '0, old, err_rd, d0, d1);
        if (do_wr) do_phase(ch, 1'b1, idx, exp_wdata, $urandom, err_wr, d2, d3);
        check("done_latency", 64'(cyc - start), 64'(exp_lat));
        hold = rnd ? $urandom_range(2) : 0;
        for (int k = 0; k <= hold; k++) begin
            check("done_ovalid", csr_o_valid, 1'b1);
            check("done_wdat", csr_o_wbck_wdat, exp_wbck);
            check("done_err", csr_o_wbck_err, exp_err);
            check("done_noreq", ext_req_valid, '0);
            check("done_core_quiet", {csr_ena, csr_rd_en, csr_wr_en}, 3'b0);
            if (k == hold) begin
                csr_o_ready = 1'b1; #1;
                check("done_iready", csr_i_ready, 1'b1);
            end else begin
                check("done_hold_iready", csr_i_ready, 1'b0);
                @(posedge clk); #2;
            end
        end
        @(posedge clk); #1;
        csr_i_valid = 1'b0; csr_o_ready = 1'b0; #1;
        check("post_ovalid", csr_o_valid, 1'b0);
    endtask

    task automatic core_op(input logic [11:0] idx, input int op, input bit imm,
                           input logic [XLEN-1:0] rs1v, input logic [4:0] zimm, input bit rs1is0,
                           input bit rdwen, input logic [XLEN-1:0] old, input bit ilgl, input bit ordy);
        logic [XLEN-1:0] op1;
        op1 = imm ? XLEN'(zimm) : rs1v;
        @(posedge clk); #1;
        csr_i_valid = 1'b1; csr_i_rs1 = rs1v; csr_i_rdwen = rdwen;
        csr_i_info  = mk_info(op, imm, zimm, rs1is0, idx);
        read_csr_dat = old; csr_access_ilgl = ilgl; csr_o_ready = ordy;
        #1;
        check("core_ovalid", csr_o_valid, 1'b1);
        check("core_iready", csr_i_ready, ordy);
        check("core_ena", csr_ena, ordy);
        check("core_rd_en", csr_rd_en, (op == OP_RW) ? rdwen : 1'b1);
        check("core_wr_en", csr_wr_en, (op == OP_RW) || !rs1is0);
        check("core_newval", wbck_csr_dat, model_new(op, op1, old));
        check("core_wdat", csr_o_wbck_wdat, old);
        check("core_err", csr_o_wbck_err, ilgl);
        check("core_idx", csr_idx, idx);
        check("core_noreq", ext_req_valid, '0);
        if (!ordy) begin
            @(posedge clk); #1;
            csr_o_ready = 1'b1; #1;
            check("core_ena_late", csr_ena, 1'b1);
            check("core_ovalid_late", csr_o_valid, 1'b1);
        end
        @(posedge clk); #1;
        csr_i_valid = 1'b0; csr_o_ready = 1'b0; #1;
        check("core_idle", {csr_o_valid, csr_ena, csr_rd_en, csr_wr_en}, 4'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, n;
        rst_n = 1'b0; csr_i_valid = 1'b0; csr_i_rs1 = '0; csr_i_info = '0; csr_i_rdwen = 1'b0;
        csr_access_ilgl = 1'b0; read_csr_dat = '0; ext_xs_off = '0; csr_o_ready = 1'b0;
        clear_rsp();
        repeat (2) @(posedge clk);
        #2;
        check("rst_ovalid", csr_o_valid, 1'b0);
        check("rst_iready", csr_i_ready, 1'b0);
        check("rst_req_valid", ext_req_valid, '0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Core CSRRS 0xF0 | 0x0F
        core_op(12'h300, OP_RS, 1'b0, 32'h0000_00F0, 5'd0, 1'b0, 1'b1, 32'h0F, 1'b0, 1'b1);
        // Ext ch1 CSRRC, rs1=3, old=0xF -> write 0xC, result 0xF, 5 cycles
        ext_op(12'hF05, OP_RC, 1'b0, 32'h3, 5'd0, 1'b0, 1'b1, 32'hF, 1'b0, 1'b0, 1'b0);
        // Ext CSRRW without rd: single write phase, wdat 0
        ext_op(12'hE21, OP_RW, 1'b0, 32'hCAFE_F00D, 5'd0, 1'b0, 1'b0, 32'h1234, 1'b0, 1'b0, 1'b0);
        // Disabled channel 0 falls back to the core path
        ext_xs_off = 2'b01;
        core_op(12'hE10, OP_RW, 1'b0, 32'hA5A5_0000, 5'd0, 1'b0, 1'b1, 32'h77, 1'b0, 1'b1);
        ext_xs_off = 2'b00;
        // Read error skips the write
        ext_op(12'hE44, OP_RS, 1'b1, 32'h0, 5'd7, 1'b0, 1'b1, 32'h5500, 1'b1, 1'b0, 1'b0);
        // Write error after a clean read
        ext_op(12'hF44, OP_RC, 1'b0, 32'hFF, 5'd0, 1'b0, 1'b1, 32'hFFFF, 1'b0, 1'b1, 1'b0);

        // Reset while waiting for a read response: stale response must be dropped
        @(posedge clk); #1;
        csr_i_valid = 1'b1; csr_i_rs1 = 32'h1; csr_i_rdwen = 1'b1;
        csr_i_info = mk_info(OP_RS, 1'b0, 5'd0, 1'b0, 12'hE00);
        @(posedge clk); #1; ext_req_ready[0] = 1'b1;
        @(posedge clk); #1; clear_rsp();
        rst_n = 1'b0; csr_i_valid = 1'b0;
        ext_rsp_valid[0] = 1'b1; ext_rsp_rdata[31:0] = 32'hDEAD_BEEF;
        @(posedge clk); #1; rst_n = 1'b1; clear_rsp(); #1;
        check("midrst_ovalid", csr_o_valid, 1'b0);
        check("midrst_noreq", ext_req_valid, '0);
        @(posedge clk); #2;
        check("midrst_idle", {csr_o_valid, csr_i_ready}, 2'b0);
        core_op(12'h341, OP_RC, 1'b1, 32'h0, 5'h1F, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);

`ifdef E203_CSRCTRL_TIMEOUT_EN
        // No read response: timeout after 4 wait cycles
        @(posedge clk); #1;
        csr_i_valid = 1'b1; csr_i_rs1 = 32'h1; csr_i_rdwen = 1'b1; csr_o_ready = 1'b0;
        csr_i_info = mk_info(OP_RS, 1'b0, 5'd0, 1'b0, 12'hF10);
        #1; start = cyc;
        @(posedge clk); #1; ext_req_ready[1] = 1'b1;
        @(posedge clk); #1; clear_rsp(); #1;
        n = 0;
        while (!csr_o_valid && n < 20) begin @(posedge clk); #2; n++; end
        check("timeout_latency", 64'(cyc - start), 64'd6);
        check("timeout_err", csr_o_wbck_err, 1'b1);
        csr_o_ready = 1'b1;
        @(posedge clk); #1; csr_i_valid = 1'b0; csr_o_ready = 1'b0;
`endif

        for (int i = 0; i < 60; i++) begin
            int op, ch;
            bit imm, rs1is0;
            logic [XLEN-1:0] rs1v;
            logic [4:0] zimm;
            logic [11:0] idx;
            op = $urandom_range(2);
            imm = $urandom_range(1);
            rs1is0 = ($urandom_range(3) == 0);
            rs1v = rs1is0 ? '0 : $urandom;
            zimm = rs1is0 ? 5'd0 : 5'($urandom_range(31));
            if (!rs1is0 && imm && zimm == 0) zimm = 5'd1;
            ext_xs_off = ($urandom_range(4) == 0) ? NEXT'($urandom_range(3)) : '0;
            if ($urandom_range(2) == 0) begin
                idx = {4'($urandom_range(13)), 8'($urandom)};
                core_op(idx, op, imm, rs1v, zimm, rs1is0, $urandom_range(1), $urandom,
                        $urandom_range(1), $urandom_range(1));
            end else begin
                ch  = $urandom_range(1);
                idx = {4'hE + 4'(ch), 8'($urandom)};
                if (ext_xs_off[ch])
                    core_op(idx, op, imm, rs1v, zimm, rs1is0, $urandom_range(1), $urandom,
                            1'b0, 1'b1);
                else
                    ext_op(idx, op, imm, rs1v, zimm, rs1is0, $urandom_range(1), $urandom,
                           ($urandom_range(6) == 0), ($urandom_range(6) == 0), 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
